serializador_param: RTL and testbench
=====================================

SERIALIZADOR_PARAM -- requirements
Module: serializador_param

Interface
REQ-001 Parameter ANCHO, default 10, SHALL set the parallel word width in bits; legal range 2..64.
REQ-002 Parameter MSB_PRIMERO, default 0, SHALL set bit order: 0 sends bit 0 first, 1 sends bit ANCHO-1 first.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_L  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 entradas  input  ANCHO  SHALL carry the parallel word to serialise.
REQ-006 valido_entrada  input  1  SHALL mark entradas as valid.
REQ-007 listo  output  1  SHALL indicate the block accepts a word on the current edge.
REQ-008 salida  output  1  SHALL be the registered serial data bit.
REQ-009 valido_salida  output  1  SHALL be high on every cycle salida carries a frame bit.
REQ-010 inicio_trama  output  1  SHALL be high only while the first frame bit is on salida.
REQ-011 fin_trama  output  1  SHALL be high only while the last frame bit is on salida.

Function
REQ-012 Frame length L SHALL be ANCHO bits, or ANCHO+1 when SERIAL_PARIDAD_EN is defined.
REQ-013 State machine SHALL have two states, REPOSO and TRANSMITE, plus a bit counter of width clog2(L).
REQ-014 listo SHALL be combinational: high in REPOSO, or in TRANSMITE when the counter equals L-1; otherwise low.
REQ-015 Acceptance SHALL occur on a rising edge where valido_entrada and listo are both high; entradas is then captured into an internal holding register.
REQ-016 On acceptance, the first frame bit SHALL appear on salida, with valido_salida and inicio_trama high, in the cycle after that edge (latency 1).
REQ-017 In TRANSMITE, each rising edge SHALL advance salida to the next bit in the order set by MSB_PRIMERO.
REQ-018 Changes on entradas after acceptance SHALL NOT affect the frame in progress.
REQ-019 valido_entrada while listo is low SHALL be ignored; the sender holds the word until accepted.
REQ-020 Acceptance on the last-bit edge SHALL start the next frame immediately, with no idle cycle between frames.
REQ-021 If the last bit completes with no acceptance, the FSM SHALL return to REPOSO, and salida and valido_salida SHALL be 0.
REQ-022 In REPOSO, salida, valido_salida, inicio_trama and fin_trama SHALL be 0.
REQ-023 When ANCHO=2 and parity is disabled, inicio_trama and fin_trama SHALL never be high together; for L=1 this is not applicable, since ANCHO is at least 2.

Reset
REQ-024 reset_L low SHALL immediately force the FSM to REPOSO, the counter to 0, the holding register to 0, and salida, valido_salida, inicio_trama and fin_trama to 0, regardless of clk.
REQ-025 Reset asserted mid-frame SHALL discard the frame; no partial bits SHALL follow deassertion.
REQ-026 listo SHALL be 1 while reset_L is low and on the first edge after deassertion.

Configuration
REQ-027 Macro SERIAL_PARIDAD_EN SHALL compile in one even-parity bit (XOR of all ANCHO data bits), sent after the last data bit; fin_trama then marks the parity bit.
REQ-028 Without SERIAL_PARIDAD_EN, no parity logic SHALL exist and L=ANCHO.

Verification
REQ-029 ANCHO=10, MSB_PRIMERO=0, entradas=10'b1100110101, single accept -> salida 1,0,1,0,1,1,0,0,1,1 over 10 cycles starting one cycle after acceptance; inicio_trama on cycle 1, fin_trama on cycle 10; then REPOSO.
REQ-030 Same word with MSB_PRIMERO=1 -> salida 1,1,0,0,1,1,0,1,0,1.
REQ-031 valido_entrada held high with words 10'h3FF then 10'h000 -> 20 contiguous valido_salida cycles (ten 1s, then ten 0s); listo is high only on the 10th bit of the first frame.
REQ-032 entradas changed to 10'h2AA on cycle 4 of a frame carrying 10'h155 -> output stays 10'h155 serialised.
REQ-033 reset_L pulsed low on bit 5 -> all outputs 0 at once, listo=1; the next accepted word serialises from its first bit.
REQ-034 With SERIAL_PARIDAD_EN, entradas=10'b0000000111 -> 11-bit frame ending with parity 1; fin_trama is high on the 11th bit.

Source files
------------

// File: rtl/serializador_param.sv
// Parameterised parallel-to-serial converter with frame markers and back-to-back framing.
// Optional even-parity bit after the data bits when SERIAL_PARIDAD_EN is defined.
module serializador_param #(
    parameter int unsigned ANCHO       = 10,
    parameter bit          MSB_PRIMERO = 1'b0
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [ANCHO-1:0] entradas,
    input  logic             valido_entrada,
    output logic             listo,
    output logic             salida,
    output logic             valido_salida,
    output logic             inicio_trama,
    output logic             fin_trama
);

`ifdef SERIAL_PARIDAD_EN
    localparam int unsigned L = ANCHO + 1;
`else
    localparam int unsigned L = ANCHO;
`endif
    localparam int unsigned     CW     = $clog2(L);
    localparam logic [CW-1:0]   ULTIMO = CW'(L - 1);

    typedef enum logic {StReposo, StTransmite} estado_t;

    estado_t          r_estado, w_estado_sig;
    logic [CW-1:0]    r_cnt, w_cnt_sig;
    logic [ANCHO-1:0] r_hold;
    logic             r_salida, r_valido, r_inicio, r_fin;
    logic             w_salida_sig, w_valido_sig, w_inicio_sig, w_fin_sig;
    logic             w_acepta, w_tx, w_bit;
    logic [ANCHO-1:0] w_src;
    int               w_idx, w_sel;

    // State register: FSM, bit counter, holding register and registered outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_estado <= StReposo;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_salida <= 1'b0;
            r_valido <= 1'b0;
            r_inicio <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_cnt    <= w_cnt_sig;
            if (w_acepta) begin
                r_hold <= entradas;
            end
            r_salida <= w_salida_sig;
            r_valido <= w_valido_sig;
            r_inicio <= w_inicio_sig;
            r_fin    <= w_fin_sig;
        end
    end

    // Next-state logic; a frame ending with a new acceptance restarts at bit 0 without idling.
    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = r_cnt;
        unique case (r_estado)
            StReposo: begin
                if (w_acepta) begin
                    w_estado_sig = StTransmite;
                    w_cnt_sig    = '0;
                end
            end
            StTransmite: begin
                if (r_cnt == ULTIMO) begin
                    w_cnt_sig    = '0;
                    w_estado_sig = w_acepta ? StTransmite : StReposo;
                end else begin
                    w_cnt_sig = r_cnt + 1'b1;
                end
            end
            default: begin
                w_estado_sig = StReposo;
                w_cnt_sig    = '0;
            end
        endcase
    end

    // Output logic: listo plus the values the output registers take on the next edge.
    always_comb begin
        listo    = (r_estado == StReposo) || (r_cnt == ULTIMO);
        w_acepta = valido_entrada && listo;
        w_src    = w_acepta ? entradas : r_hold;
        w_tx     = (w_estado_sig == StTransmite);
        w_idx    = int'(w_cnt_sig);
        w_sel    = MSB_PRIMERO ? (int'(ANCHO) - 1 - w_idx) : w_idx;
        w_bit    = 1'b0;
        for (int i = 0; i < int'(ANCHO); i++) begin
            if (i == w_sel) begin
                w_bit = w_src[i];
            end
        end
`ifdef SERIAL_PARIDAD_EN
        if (w_idx == int'(ANCHO)) begin
            w_bit = ^w_src;
        end
`endif
        w_salida_sig = w_tx && w_bit;
        w_valido_sig = w_tx;
        w_inicio_sig = w_tx && (w_cnt_sig == '0);
        w_fin_sig    = w_tx && (w_cnt_sig == ULTIMO);
    end

    assign salida        = r_salida;
    assign valido_salida = r_valido;
    assign inicio_trama  = r_inicio;
    assign fin_trama     = r_fin;

endmodule

// File: tb/tb_serializador_param.sv
// Bench for serializador_param: LSB-first and MSB-first instances share stimulus and are
// compared against a queue-based frame model, fixed vectors and directed corner sequences.
module tb_serializador_param;

    localparam int ANCHO = 10;
`ifdef SERIAL_PARIDAD_EN
    localparam int L = ANCHO + 1;
`else
    localparam int L = ANCHO;
`endif

    logic             clk = 1'b0;
    logic             reset_L;
    logic             valido_entrada;
    logic [ANCHO-1:0] entradas;
    logic listo0, salida0, valido0, inicio0, fin0;
    logic listo1, salida1, valido1, inicio1, fin1;

    always #5 clk = ~clk;

    serializador_param #(.ANCHO(ANCHO), .MSB_PRIMERO(1'b0)) u_dut0 (
        .clk(clk), .reset_L(reset_L), .entradas(entradas), .valido_entrada(valido_entrada),
        .listo(listo0), .salida(salida0), .valido_salida(valido0),
        .inicio_trama(inicio0), .fin_trama(fin0)
    );

    serializador_param #(.ANCHO(ANCHO), .MSB_PRIMERO(1'b1)) u_dut1 (
        .clk(clk), .reset_L(reset_L), .entradas(entradas), .valido_entrada(valido_entrada),
        .listo(listo1), .salida(salida1), .valido_salida(valido1),
        .inicio_trama(inicio1), .fin_trama(fin1)
    );

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } obit_t;

    typedef struct {
        logic [ANCHO-1:0] word;
        logic [ANCHO-1:0] exp_lsb;  // bit 9 is the first bit on the line
        logic [ANCHO-1:0] exp_msb;
    } vec_t;

    obit_t       q0[$];
    obit_t       q1[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cidx;
    int          listo_seen;
    logic        last_acc;
    logic [31:0] obs0, obs1, ost, ofn;
    vec_t        tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic fbit(input logic [ANCHO-1:0] w, input bit msb, input int i);
        if (i >= ANCHO) return ^w;
        return msb ? w[ANCHO-1-i] : w[i];
    endfunction

    task automatic push_frame(input logic [ANCHO-1:0] w);
        for (int i = 0; i < L; i++) begin
            q0.push_back(obit_t'{fbit(w, 1'b0, i), (i == 0), (i == L - 1)});
            q1.push_back(obit_t'{fbit(w, 1'b1, i), (i == 0), (i == L - 1)});
        end
    endtask

    task automatic chk_out();
        obit_t e0;
        obit_t e1;
        logic  v;
        v  = (q0.size() != 0);
        e0 = v ? q0[0] : '0;
        e1 = v ? q1[0] : '0;
        chk("out_lsb", {salida0, valido0, inicio0, fin0}, {e0.b, v, e0.first, e0.last});
        chk("out_msb", {salida1, valido1, inicio1, fin1}, {e1.b, v, e1.first, e1.last});
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic vin, input logic [ANCHO-1:0] din);
        logic exp_listo;
        valido_entrada = vin;
        entradas       = din;
        #1;
        exp_listo = (q0.size() <= 1);
        chk("listo_lsb", listo0, exp_listo);
        chk("listo_msb", listo1, exp_listo);
        if (listo0) listo_seen++;
        last_acc = vin && exp_listo;
        @(posedge clk);
        if (q0.size() > 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (last_acc) push_frame(din);
        @(negedge clk);
        chk_out();
        if (valido0 && cidx < 32) begin
            obs0[cidx] = salida0;
            obs1[cidx] = salida1;
            ost[cidx]  = inicio0;
            ofn[cidx]  = fin0;
            cidx++;
        end
    endtask

    task automatic do_reset();
        reset_L        = 1'b0;
        valido_entrada = 1'b0;
        #1;
        chk("rst_out_lsb", {salida0, valido0, inicio0, fin0}, 4'b0000);
        chk("rst_out_msb", {salida1, valido1, inicio1, fin1}, 4'b0000);
        chk("rst_listo", {listo0, listo1}, 2'b11);
        q0.delete();
        q1.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold", {salida0, valido0, salida1, valido1}, 4'b0000);
        reset_L = 1'b1;
    endtask

    task automatic clear_obs();
        cidx = 0;
        obs0 = '0;
        obs1 = '0;
        ost  = '0;
        ofn  = '0;
    endtask

    initial begin
        logic [ANCHO-1:0] e0, e1, rev;
        int               iters;

        tbl[0] = '{10'b1100110101, 10'b1010110011, 10'b1100110101};
        tbl[1] = '{10'h3FF,        10'h3FF,        10'h3FF};
        tbl[2] = '{10'h001,        10'b1000000000, 10'b0000000001};
        tbl[3] = '{10'h155,        10'b1010101010, 10'b0101010101};

        reset_L        = 1'b0;
        valido_entrada = 1'b0;
        entradas       = '0;
        listo_seen     = 0;
        last_acc       = 1'b0;
        clear_obs();
        #1;
        chk("reset_out", {salida0, valido0, inicio0, fin0, salida1, valido1}, 6'b0);
        chk("reset_listo", {listo0, listo1}, 2'b11);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;

        // Fixed vectors: single accept, then idle long enough to return to REPOSO.
        for (int t = 0; t < 4; t++) begin
            clear_obs();
            cycle(1'b1, tbl[t].word);
            repeat (L + 1) cycle(1'b0, ~tbl[t].word);
            for (int k = 0; k < ANCHO; k++) begin
                e0[k] = tbl[t].exp_lsb[ANCHO-1-k];
                e1[k] = tbl[t].exp_msb[ANCHO-1-k];
            end
            chk("tbl_lsb", obs0[ANCHO-1:0], e0);
            chk("tbl_msb", obs1[ANCHO-1:0], e1);
            chk("tbl_len", cidx, L);
            chk("tbl_inicio", ost, 32'd1);
            chk("tbl_fin", ofn, 32'd1 << (L - 1));
`ifdef SERIAL_PARIDAD_EN
            chk("tbl_par", obs0[ANCHO], ^tbl[t].word);
`endif
        end

        // Back-to-back frames with valido_entrada held high.
        clear_obs();
        cycle(1'b1, 10'h3FF);
        listo_seen = 0;
        iters      = 0;
        do begin
            cycle(1'b1, 10'h000);
            iters++;
        end while (!last_acc && iters < 3 * L);
        chk("b2b_wait", iters, L);
        chk("b2b_listo", listo_seen, 1);
        repeat (L + 2) cycle(1'b0, 10'h000);
        chk("b2b_len", cidx, 2 * L);
        chk("b2b_bits", obs0, 32'h3FF);

        // Input changes after acceptance do not disturb the frame.
        clear_obs();
        cycle(1'b1, 10'h155);
        repeat (3) cycle(1'b0, 10'h155);
        repeat (L) cycle(1'b0, 10'h2AA);
        for (int k = 0; k < ANCHO; k++) rev[k] = tbl[3].word[ANCHO-1-k];
        chk("hold_lsb", obs0[ANCHO-1:0], 10'h155);
        chk("hold_msb", obs1[ANCHO-1:0], rev);

        // Reset during bit 5, then a fresh frame starts from its first bit.
        cycle(1'b1, 10'h2C3);
        repeat (4) cycle(1'b0, 10'h000);
        do_reset();
        clear_obs();
        cycle(1'b1, 10'h0F0);
        repeat (L + 1) cycle(1'b0, 10'h000);
        chk("rst_next_bits", obs0[ANCHO-1:0], 10'h0F0);
        chk("rst_next_len", cidx, L);
        chk("rst_next_inicio", ost, 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 2) != 0, ANCHO'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
